utx_cfg: RTL and testbench

Next-generation UART transmitter with run-time baud divisor and frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits). It has a small input FIFO so a host can queue bytes, and back-to-back frames are sent with no idle gap. It sits between the timestamp formatter and the serial TX pin.

---
 rtl/utx_cfg.sv | 195 +++++++++++++++++++
 tb/tb_utx_cfg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/utx_cfg.sv
// UART transmitter with run-time divisor and frame format (5-8 data bits, parity, 1/2 stop bits).
// A small input FIFO feeds the shifter so queued bytes go out back-to-back with no idle gap.
module utx_cfg #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          serialout,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [1:0]           bits_reg;
    logic [1:0]           parity_reg;
    logic                 stop2_reg;
    logic [7:0]           shift_reg;
    logic [2:0]           idx_reg;
    logic                 acc_reg;
    logic                 stop_cnt_reg;
    logic                 tx_reg;
    logic                 done_reg;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;

    logic tick;
    logic last_bit;
    logic last_stop;
    logic frame_end;
    logic par_en;
    logic acc_next;
    logic fifo_empty;
    logic push;
    logic pop;

    // A divisor of 0 would give a one-clock bit; it is promoted to 1.
    assign div_eff    = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    assign tick       = (cnt_reg == div_reg);
    assign last_bit   = (idx_reg == ({1'b0, bits_reg} + 3'd4));
    assign last_stop  = !stop2_reg || stop_cnt_reg;
    assign frame_end  = (state_reg == S_STOP) && tick && last_stop;
    assign par_en     = (parity_reg == 2'b01) || (parity_reg == 2'b10);
    assign acc_next   = acc_reg ^ shift_reg[0];

    assign fifo_empty = (level_reg == '0);
    assign in_ready   = (level_reg != LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    // A new frame starts from IDLE or straight out of the last stop bit.
    assign pop        = !fifo_empty && ((state_reg == S_IDLE) || frame_end);

    assign serialout  = tx_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != S_IDLE) || !fifo_empty;
    assign fifo_level = level_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            bits_reg     <= '0;
            parity_reg   <= '0;
            stop2_reg    <= 1'b0;
            shift_reg    <= '0;
            idx_reg      <= '0;
            acc_reg      <= 1'b0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg != S_IDLE) begin
                cnt_reg <= tick ? '0 : cnt_reg + DIV_WIDTH'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                end
                S_START: begin
                    if (tick) begin
                        state_reg <= S_DATA;
                        tx_reg    <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        acc_reg   <= acc_next;
                        shift_reg <= shift_reg >> 1;
                        idx_reg   <= idx_reg + 3'd1;
                        if (last_bit) begin
                            if (par_en) begin
                                state_reg <= S_PARITY;
                                tx_reg    <= (parity_reg == 2'b10) ? ~acc_next : acc_next;
                            end else begin
                                state_reg <= S_STOP;
                                tx_reg    <= 1'b1;
                            end
                        end else begin
                            tx_reg <= shift_reg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state_reg <= S_STOP;
                        tx_reg    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (!last_stop) begin
                            stop_cnt_reg <= 1'b1;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase

            // Frame load overrides whatever the case above decided for this edge.
            if (pop) begin
                state_reg    <= S_START;
                tx_reg       <= 1'b0;
                shift_reg    <= mem[rd_ptr_reg];
                cnt_reg      <= '0;
                div_reg      <= div_eff;
                bits_reg     <= cfg_bits;
                parity_reg   <= cfg_parity;
                stop2_reg    <= cfg_stop2;
                idx_reg      <= '0;
                acc_reg      <= 1'b0;
                stop_cnt_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_utx_cfg.sv
// Randomized bench for utx_cfg: a frame-level model expands each queued byte into the
// expected per-clock line waveform and tracks FIFO occupancy, done and busy.
module tb_utx_cfg;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] baud_div;
    logic [1:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        serialout;
    logic        busy;
    logic        done;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    bit         line_q[$];
    logic [7:0] fifo_q[$];
    bit         exp_done = 1'b0;

    utx_cfg #(.DIV_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .baud_div   (baud_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .serialout  (serialout),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int bit_period();
        return ((baud_div == 16'd0) ? 1 : int'(baud_div)) + 1;
    endfunction

    function automatic int frame_len();
        int p = (cfg_parity == 2'd1 || cfg_parity == 2'd2) ? 1 : 0;
        int s = cfg_stop2 ? 2 : 1;
        return (1 + int'(cfg_bits) + 5 + p + s) * bit_period();
    endfunction

    // Expand one byte into its line levels, one entry per clock.
    task automatic build_frame(input logic [7:0] d);
        bit seq[$];
        bit ones = 1'b0;
        int nbits = int'(cfg_bits) + 5;
        int per = bit_period();
        seq.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            seq.push_back(d[i]);
            ones ^= d[i];
        end
        if (cfg_parity == 2'd1) seq.push_back(ones);
        else if (cfg_parity == 2'd2) seq.push_back(!ones);
        seq.push_back(1'b1);
        if (cfg_stop2) seq.push_back(1'b1);
        foreach (seq[i]) begin
            for (int k = 0; k < per; k++) line_q.push_back(seq[i]);
        end
        $display("frame t=%0t byte=%02h bits=%0d parity=%0d stop=%0d clk_per_bit=%0d",
                 $time, d, nbits, cfg_parity, cfg_stop2 ? 2 : 1, per);
    endtask

    task automatic model_edge();
        bit do_push = in_valid && (fifo_q.size() < DEPTH);
        bit tmp;
        logic [7:0] d;
        exp_done = 1'b0;
        if (line_q.size() > 0) begin
            tmp = line_q.pop_front();
            if (line_q.size() == 0) exp_done = 1'b1;
        end
        if (line_q.size() == 0 && fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            build_frame(d);
        end
        if (do_push) fifo_q.push_back(in_data);
    endtask

    task automatic check_outputs();
        bit exp_line = (line_q.size() > 0) ? line_q[0] : 1'b1;
        check_val("serialout", 32'(serialout), 32'(exp_line));
        check_val("done", 32'(done), 32'(exp_done));
        check_val("fifo_level", 32'(fifo_level), 32'(fifo_q.size()));
        check_val("in_ready", 32'(in_ready), 32'(fifo_q.size() < DEPTH));
        check_val("busy", 32'(busy), 32'(line_q.size() > 0 || fifo_q.size() > 0));
    endtask

    // One clock: model updates at the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(output int dones);
        int n = 0;
        dones = 0;
        while ((line_q.size() > 0 || fifo_q.size() > 0) && n < 5000) begin
            step();
            n++;
            if (done) dones++;
        end
        check_val("drain_bound", 32'(n < 5000), 32'd1);
        step();
        step();
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit s2);
        baud_div   = 16'(div);
        cfg_bits   = 2'(bits);
        cfg_parity = 2'(par);
        cfg_stop2  = s2;
    endtask

    // Asynchronous reset applied between clock edges, checked before the next edge.
    task automatic do_reset();
        #3;
        rstn = 1'b0;
        #1;
        line_q.delete();
        fifo_q.delete();
        exp_done = 1'b0;
        check_val("rst_serialout", 32'(serialout), 32'd1);
        check_val("rst_fifo_level", 32'(fifo_level), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        int         div;
        int         bits;
        int         par;
        bit         s2;
        logic [7:0] d;
    } dir_t;

    initial begin
        dir_t dirs[3];
        int   k;
        int   dones;

        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        set_cfg(3, 3, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_val("init_serialout", 32'(serialout), 32'd1);
        check_val("init_fifo_level", 32'(fifo_level), 32'd0);
        check_val("init_busy", 32'(busy), 32'd0);
        check_val("init_done", 32'(done), 32'd0);
        check_val("init_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;
        step();

        // Single frames with explicit end-to-end length checks.
        dirs[0] = '{div: 3, bits: 3, par: 0, s2: 1'b0, d: 8'h55};
        dirs[1] = '{div: 1, bits: 2, par: 1, s2: 1'b1, d: 8'h41};
        dirs[2] = '{div: 2, bits: 0, par: 2, s2: 1'b0, d: 8'hFF};
        foreach (dirs[i]) begin
            set_cfg(dirs[i].div, dirs[i].bits, dirs[i].par, dirs[i].s2);
            push_byte(dirs[i].d);
            k = 0;
            do begin
                step();
                k++;
            end while (!done && k < 500);
            check_val("frame_len", 32'(k), 32'(1 + frame_len()));
            drain(dones);
        end

        // Burst of six with divisor 0: one into the shifter, four queued, one dropped.
        set_cfg(0, 3, 0, 1'b0);
        for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
        drain(dones);
        check_val("burst_done_cnt", 32'(dones), 32'd5);

        // Frame format change while a frame is on the line.
        set_cfg(1, 3, 0, 1'b0);
        push_byte(8'hC3);
        push_byte(8'h3C);
        for (int i = 0; i < 5; i++) step();
        cfg_bits = 2'd0;
        drain(dones);
        check_val("cfgchg_done_cnt", 32'(dones), 32'd2);

        // Reset in the middle of a queued burst, then a fresh byte.
        set_cfg(2, 3, 0, 1'b0);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        for (int i = 0; i < 10; i++) step();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        set_cfg(2, 3, 0, 1'b0);
        push_byte(8'hA5);
        drain(dones);
        check_val("post_rst_done_cnt", 32'(dones), 32'd1);

        // Randomized traffic with occasional mid-stream config changes and resets.
        for (int it = 0; it < 40; it++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
            for (int c = 0; c < 60; c++) begin
                in_valid = ($urandom_range(0, 2) == 0);
                in_data  = 8'($urandom);
                if ($urandom_range(0, 49) == 0) cfg_bits = 2'($urandom_range(0, 3));
                step();
            end
            in_valid = 1'b0;
            if (it == 20) do_reset();
        end
        drain(dones);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
